// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch controller: FSM state encoding and default widths.
package fetch_pkg;

  localparam int PC_W  = 12;
  localparam int CYC_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select: halt/stall hold, taken branch adds a relative offset, else increment.
import fetch_pkg::*;

module pc_next #(
  parameter int D = PC_W
) (
  input  logic [D-1:0] pc_i,
  input  logic         halt_i,
  input  logic         stall_i,
  input  logic         branch_i,
  input  logic         taken_i,
  input  logic [D-1:0] target_i,
  output logic [D-1:0] pc_o
);

  // Halt holds PC so it keeps pointing at the halt instruction.
  always_comb begin
    pc_o = pc_i + D'(1);
    if (halt_i || stall_i) begin
      pc_o = pc_i;
    end else if (branch_i && taken_i) begin
      pc_o = pc_i + target_i;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Program fetch controller: IDLE/RUN/DONE FSM, PC register and saturating run-cycle counter.
import fetch_pkg::*;

module fetch_ctrl #(
  parameter int D  = PC_W,
  parameter int CW = CYC_W
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          Stall,
  input  logic          Branch,
  input  logic          Taken,
  input  logic [D-1:0]  Target,
  input  logic          Halt_req,
  output logic [D-1:0]  PC,
  output logic          Fetch_valid,
  output logic          Done,
  output logic [CW-1:0] Cycles
);

  state_e          state_q, state_d;
  logic [D-1:0]    pc_q, pc_d, pc_nxt;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic            fv_q, fv_d;
  logic            done_q, done_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  pc_next #(.D(D)) u_pc_next (
    .pc_i     (pc_q),
    .halt_i   (Halt_req),
    .stall_i  (Stall),
    .branch_i (Branch),
    .taken_i  (Taken),
    .target_i (Target),
    .pc_o     (pc_nxt)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      RUN: begin
        cyc_d = sat_inc(cyc_q);
        pc_d  = pc_nxt;
        if (Halt_req) state_d = DONE;
      end
      IDLE, DONE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = '0;
          cyc_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Status flags are registered copies of the next state so they track state_q exactly.
    fv_d   = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cyc_q   <= '0;
      fv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
      fv_q    <= fv_d;
      done_q  <= done_d;
    end
  end

  assign PC          = pc_q;
  assign Fetch_valid = fv_q;
  assign Done        = done_q;
  assign Cycles      = cyc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural reference model and literal spot checks.
module tb_fetch_ctrl;

  localparam int D   = 12;
  localparam int CW  = 4;
  localparam int PCM = 1 << D;
  localparam int CMX = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Start = 1'b0, Stall = 1'b0, Branch = 1'b0, Taken = 1'b0, Halt_req = 1'b0;
  logic [D-1:0]  Target = '0;
  logic [D-1:0]  PC;
  logic          Fetch_valid, Done;
  logic [CW-1:0] Cycles;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Reference model: mode 0=idle, 1=running, 2=finished.
  int m_mode = 0;
  int m_pc   = 0;
  int m_cyc  = 0;

  fetch_ctrl #(.D(D), .CW(CW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .Branch(Branch),
    .Taken(Taken), .Target(Target), .Halt_req(Halt_req), .PC(PC),
    .Fetch_valid(Fetch_valid), .Done(Done), .Cycles(Cycles)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_mode = 0; m_pc = 0; m_cyc = 0;
    end else if (m_mode == 1) begin
      m_cyc = (m_cyc < CMX) ? m_cyc + 1 : CMX;
      if (Halt_req)             m_mode = 2;
      else if (Stall)           m_pc = m_pc;
      else if (Branch && Taken) m_pc = (m_pc + int'(Target)) % PCM;
      else                      m_pc = (m_pc + 1) % PCM;
    end else if (Start) begin
      m_mode = 1; m_pc = 0; m_cyc = 0;
    end
  end

  always @(negedge Clk) begin
    if (chk_on) begin
      chk("model_pc",     32'(PC),          32'(m_pc));
      chk("model_fvalid", 32'(Fetch_valid), 32'(m_mode == 1));
      chk("model_done",   32'(Done),        32'(m_mode == 2));
      chk("model_cycles", 32'(Cycles),      32'(m_cyc));
    end
  end

  // Called at a falling edge: apply inputs, return at the next falling edge.
  task automatic drive(input logic s, input logic st, input logic br, input logic tk,
                       input logic [D-1:0] tgt, input logic h);
    Start = s; Stall = st; Branch = br; Taken = tk; Target = tgt; Halt_req = h;
    @(negedge Clk);
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12 Reset_n = 1'b1;
    chk_on = 1'b1;
    @(negedge Clk);
    chk("reset_pc", 32'(PC), 32'd0);
    chk("reset_fv", 32'(Fetch_valid), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_cyc", 32'(Cycles), 32'd0);

    // Start then five plain run cycles.
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("start_fv", 32'(Fetch_valid), 32'd1);
    chk("start_pc", 32'(PC), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      idle_cycle();
      chk("seq_pc", 32'(PC), 32'(i));
    end
    chk("seq_cyc", 32'(Cycles), 32'd5);

    drive(1'b0, 1'b0, 1'b1, 1'b1, 12'hFFF, 1'b0);
    chk("br_m1_a", 32'(PC), 32'd4);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 12'hFFF, 1'b0);
    chk("br_m1_b", 32'(PC), 32'd3);
    idle_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 12'hFFB, 1'b0);
    chk("br_neg_wrap", 32'(PC), 32'hFFF);
    idle_cycle();
    chk("inc_wrap", 32'(PC), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 12'd50, 1'b0);
    chk("not_taken", 32'(PC), 32'd1);
    chk("cyc_11", 32'(Cycles), 32'd11);

    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, 12'd20, 1'b0);
      chk("stall_pc", 32'(PC), 32'd1);
      chk("stall_cyc", 32'(Cycles), 32'(11 + i));
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 12'd20, 1'b0);
    chk("br_after_stall", 32'(PC), 32'd21);
    chk("cyc_max", 32'(Cycles), 32'd15);
    idle_cycle();
    chk("cyc_sat", 32'(Cycles), 32'd15);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 12'd0, 1'b0);
    chk("self_loop", 32'(PC), 32'd22);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 12'hFF3, 1'b0);
    chk("to_nine", 32'(PC), 32'd9);

    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("halt_done", 32'(Done), 32'd1);
    chk("halt_fv", 32'(Fetch_valid), 32'd0);
    chk("halt_pc", 32'(PC), 32'd9);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 12'd5, 1'b1);
    chk("done_hold_pc", 32'(PC), 32'd9);
    chk("done_hold_cyc", 32'(Cycles), 32'd15);

    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("restart_pc", 32'(PC), 32'd0);
    chk("restart_cyc", 32'(Cycles), 32'd0);
    chk("restart_fv", 32'(Fetch_valid), 32'd1);
    chk("restart_done", 32'(Done), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("start_in_run", 32'(PC), 32'd1);
    for (int i = 0; i < 6; i++) idle_cycle();
    chk("pc_seven", 32'(PC), 32'd7);

    // Asynchronous reset pulse in the high phase of the clock.
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_pc", 32'(PC), 32'd0);
    chk("async_fv", 32'(Fetch_valid), 32'd0);
    chk("async_done", 32'(Done), 32'd0);
    chk("async_cyc", 32'(Cycles), 32'd0);
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("rst_start_ign", 32'(Fetch_valid), 32'd0);
    idle_cycle();
    chk("wait_idle", 32'(Fetch_valid), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("resume_pc", 32'(PC), 32'd0);
    chk("resume_fv", 32'(Fetch_valid), 32'd1);
    idle_cycle();
    chk("resume_inc", 32'(PC), 32'd1);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
